// File: rtl/assoc_array_reader.sv
// Small associative key/value table with a sequential read engine.
// Writes land in one cycle while idle; read operations (LOOKUP, FIRST,
// NEXT, DELETE) walk every entry, one per cycle, and then present a
// held response until it is consumed.
// Optional feature: define ASSOC_ARRAY_DELETE_EN to make opcode 11 remove
// the matching entry; otherwise opcode 11 always answers with a miss.
module assoc_array_reader #(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [KEY_W-1:0]         wr_key,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     rd_valid,
  input  logic [1:0]               rd_op,
  input  logic [KEY_W-1:0]         rd_key,
  output logic                     rd_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [KEY_W-1:0]         resp_key,
  output logic [DATA_W-1:0]        resp_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FIRST  = 2'b01;
  localparam logic [1:0] OP_NEXT   = 2'b10;

  logic [1:0]        state;
  logic [DEPTH-1:0]  valid;
  logic [KEY_W-1:0]  keys [DEPTH];
  logic [DATA_W-1:0] vals [DEPTH];
  logic [IDX_W-1:0]  scan_idx;

  // Request captured at accept (stage p0), running best candidate (stage p1)
  logic [1:0]        op_p0;
  logic [KEY_W-1:0]  key_p0;
  logic              best_hit_p1;
  logic [KEY_W-1:0]  best_key_p1;
  logic [DATA_W-1:0] best_data_p1;
`ifdef ASSOC_ARRAY_DELETE_EN
  logic [IDX_W-1:0]  best_idx_p1;
  logic [IDX_W-1:0]  nxt_idx;
`endif

  logic              wr_hit;
  logic [IDX_W-1:0]  wr_hit_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;

  logic              cur_vld;
  logic [KEY_W-1:0]  cur_key;
  logic [DATA_W-1:0] cur_val;
  logic              take;
  logic              nxt_hit;
  logic [KEY_W-1:0]  nxt_key;
  logic [DATA_W-1:0] nxt_data;

  assign wr_ready = (state == IDLE);
  assign rd_ready = (state == IDLE) && !wr_valid;

  // Write-side search: existing key match and lowest-index free slot
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (keys[i] == wr_key) && !wr_hit) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Scan step: decide whether the entry under the cursor beats the best so far
  always_comb begin
    cur_vld = valid[scan_idx];
    cur_key = keys[scan_idx];
    cur_val = vals[scan_idx];
    take    = 1'b0;
    case (op_p0)
      OP_LOOKUP: take = cur_vld && (cur_key == key_p0);
      OP_FIRST:  take = cur_vld && (!best_hit_p1 || (cur_key < best_key_p1));
      OP_NEXT:   take = cur_vld && (cur_key > key_p0) &&
                        (!best_hit_p1 || (cur_key < best_key_p1));
`ifdef ASSOC_ARRAY_DELETE_EN
      default:   take = cur_vld && (cur_key == key_p0);
`else
      default:   take = 1'b0;
`endif
    endcase
    nxt_hit  = best_hit_p1 | take;
    nxt_key  = take ? cur_key : best_key_p1;
    nxt_data = take ? cur_val : best_data_p1;
`ifdef ASSOC_ARRAY_DELETE_EN
    nxt_idx  = take ? scan_idx : best_idx_p1;
`endif
  end

  // Control: FSM, valid bits, count, overflow pulse and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      scan_idx    <= '0;
      best_hit_p1 <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_key    <= '0;
      resp_data   <= '0;
    end else begin
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_valid) begin
            if (!wr_hit) begin
              if (free_found) begin
                valid[free_idx] <= 1'b1;
                count           <= count + CNT_W'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end else if (rd_valid) begin
            state       <= SCAN;
            scan_idx    <= '0;
            best_hit_p1 <= 1'b0;
          end
        end
        SCAN: begin
          best_hit_p1 <= nxt_hit;
          scan_idx    <= scan_idx + IDX_W'(1);
          if (scan_idx == IDX_W'(DEPTH - 1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_hit   <= nxt_hit;
            resp_key   <= nxt_hit ? nxt_key : '0;
            resp_data  <= nxt_hit ? nxt_data : '0;
`ifdef ASSOC_ARRAY_DELETE_EN
            if ((op_p0 == 2'b11) && nxt_hit) begin
              valid[nxt_idx] <= 1'b0;
              count          <= count - CNT_W'(1);
            end
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: table contents, captured request and best-candidate payload
  always_ff @(posedge clk) begin
    if ((state == IDLE) && wr_valid) begin
      if (wr_hit) begin
        vals[wr_hit_idx] <= wr_data;
      end else if (free_found) begin
        keys[free_idx] <= wr_key;
        vals[free_idx] <= wr_data;
      end
    end
    if (rd_valid && rd_ready) begin
      op_p0  <= rd_op;
      key_p0 <= rd_key;
    end
    if (state == SCAN) begin
      best_key_p1  <= nxt_key;
      best_data_p1 <= nxt_data;
`ifdef ASSOC_ARRAY_DELETE_EN
      best_idx_p1  <= nxt_idx;
`endif
    end
  end

endmodule

// File: doc/assoc_array_reader.md
ASSOC_ARRAY_READER -- requirements
Module: assoc_array_reader

Interface
REQ-001 Parameter DEPTH, default 8: number of key/value entries (power of two, at least 2).
REQ-002 Parameter KEY_W, default 8: key width in bits.
REQ-003 Parameter DATA_W, default 32: value width in bits.
REQ-004 Port clk, input, 1 bit: single clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wr_valid, input, 1 bit: write request.
REQ-007 Port wr_key, input, KEY_W bits: write key.
REQ-008 Port wr_data, input, DATA_W bits: write value.
REQ-009 Port wr_ready, output, 1 bit: write accepted this cycle when high with wr_valid.
REQ-010 Port rd_valid, input, 1 bit: read request.
REQ-011 Port rd_op, input, 2 bits: opcode, 00 LOOKUP, 01 FIRST, 10 NEXT, 11 DELETE.
REQ-012 Port rd_key, input, KEY_W bits: key operand for LOOKUP, NEXT and DELETE.
REQ-013 Port rd_ready, output, 1 bit: read request accepted when high with rd_valid.
REQ-014 Port resp_valid, output, 1 bit: response available.
REQ-015 Port resp_ready, input, 1 bit: response consumed when high with resp_valid.
REQ-016 Port resp_hit, output, 1 bit: the operation found an entry.
REQ-017 Port resp_key, output, KEY_W bits: key found, or 0 on miss.
REQ-018 Port resp_data, output, DATA_W bits: value found, or 0 on miss.
REQ-019 Port count, output, $clog2(DEPTH)+1 bits: number of valid entries.
REQ-020 Port overflow, output, 1 bit: one-cycle pulse when a new-key write is dropped because the table is full.

Function
REQ-021 The block SHALL use FSM states IDLE, SCAN and RESP; IDLE moves to SCAN on read accept, SCAN moves to RESP after DEPTH cycles, and RESP moves to IDLE on resp_valid&&resp_ready.
REQ-022 wr_ready SHALL be high only in IDLE; rd_ready SHALL be high only in IDLE while wr_valid is low, so a write wins over a simultaneous read.
REQ-023 A write whose key matches a valid entry SHALL overwrite that entry's data; count is unchanged.
REQ-024 A write with a new key SHALL fill the lowest-index free slot and increment count.
REQ-025 A write with a new key when count==DEPTH SHALL be dropped and SHALL pulse overflow in the following cycle.
REQ-026 SCAN SHALL examine entry 0 through entry DEPTH-1, one entry per cycle; a request accepted at cycle T SHALL raise resp_valid at T+DEPTH+1.
REQ-027 LOOKUP SHALL return hit=1 with the entry's key and data when rd_key is stored, otherwise a miss.
REQ-028 FIRST SHALL return the smallest stored key (unsigned) and its data; an empty table returns a miss.
REQ-029 NEXT SHALL return the smallest stored key strictly greater than rd_key; if none exists (including rd_key all-ones), it returns a miss, with no wrap-around.
REQ-030 The resp_* outputs SHALL hold stable while resp_valid is high and resp_ready is low.
REQ-031 The rd_key and rd_op values SHALL be captured at accept; later changes SHALL not affect the response.

Reset
REQ-032 On rst, the block SHALL clear all valid bits, set the state to IDLE, and drive count, resp_valid, resp_hit, resp_key, resp_data and overflow to 0.
REQ-033 On rst, wr_ready SHALL go to 1 and rd_ready SHALL follow REQ-022 from the first cycle after reset.
REQ-034 Reset asserted during SCAN or RESP SHALL abort the operation with no response and no deletion.

Configuration
REQ-035 With ASSOC_ARRAY_DELETE_EN defined, DELETE SHALL invalidate the matching entry on entering RESP, decrement count, and respond hit=1 with the deleted key and data; a missing key responds as a miss.
REQ-036 Without ASSOC_ARRAY_DELETE_EN, opcode 11 SHALL complete with the normal latency, respond as a miss, and leave the table unchanged.

Verification
REQ-037 Write keys 80→81, 0→1, 5→9, then FIRST -> hit=1, key=0, data=1, resp_valid at T+9 (DEPTH=8); count==3.
REQ-038 NEXT rd_key=0 -> key 5, data 9; NEXT 80 -> hit=0, key=0, data=0; NEXT 255 -> miss.
REQ-039 Write key 80→42, then LOOKUP 80 -> data 42, count unchanged; LOOKUP 7 -> miss.
REQ-040 Fill 8 distinct keys, then write new key 99 -> overflow pulses once, count==8, LOOKUP 99 misses; write and read asserted together in IDLE -> write accepted, rd_ready low.
REQ-041 With ASSOC_ARRAY_DELETE_EN: DELETE 5 -> hit=1, data 9, count decrements, LOOKUP 5 misses; without the macro: hit=0, count unchanged.
REQ-042 Assert rst mid-SCAN -> no resp_valid, count==0; hold resp_ready low 5 cycles in RESP -> resp_* stable, then one handshake returns the FSM to IDLE.
